// File: rtl/cpu6_immenc_pkg.sv
// cpu6_immenc_pkg
// Shared CPU6 immediate definitions: datapath width, immediate-format codes
// and the instruction bit positions of every immediate field. The immediate
// encoder and the matching immediate decoder both take these from here, so
// the two can never disagree about where a field lives.
package cpu6_immenc_pkg;

  localparam int CPU6_XLEN         = 32;
  localparam int CPU6_IMMTYPE_SIZE = 3;

  // Immediate format codes; any other code is treated as illegal.
  typedef enum logic [CPU6_IMMTYPE_SIZE-1:0] {
    CPU6_IMMTYPE_I = 3'd0,
    CPU6_IMMTYPE_S = 3'd1,
    CPU6_IMMTYPE_B = 3'd2,
    CPU6_IMMTYPE_U = 3'd3
  } cpu6_immtype_e;

  // I format: one contiguous 12-bit field.
  localparam int CPU6_I_IMM_HI  = 31;
  localparam int CPU6_I_IMM_LO  = 20;

  // S format: upper seven bits and lower five bits split around rs2/rs1.
  localparam int CPU6_S_HI_HI   = 31;
  localparam int CPU6_S_HI_LO   = 25;
  localparam int CPU6_S_LO_HI   = 11;
  localparam int CPU6_S_LO_LO   = 7;

  // B format: S layout with imm[12] and imm[11] moved to the edge bits.
  localparam int CPU6_B_BIT12   = 31;
  localparam int CPU6_B_HI_HI   = 30;
  localparam int CPU6_B_HI_LO   = 25;
  localparam int CPU6_B_LO_HI   = 11;
  localparam int CPU6_B_LO_LO   = 8;
  localparam int CPU6_B_BIT11   = 7;

  // U format: upper twenty bits.
  localparam int CPU6_U_IMM_HI  = 31;
  localparam int CPU6_U_IMM_LO  = 12;

  // True when v[XLEN-1:lsb] are all equal, i.e. v is the sign extension of
  // its low lsb+1 bits. An arithmetic shift leaves either all zeros or all
  // ones exactly in that case.
  function automatic logic cpu6_fits_signed(input logic [CPU6_XLEN-1:0] v,
                                            input int unsigned          lsb);
    logic [CPU6_XLEN-1:0] upper;
    upper = CPU6_XLEN'($signed(v) >>> lsb);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/cpu6_immenc_pack.sv
// cpu6_immenc_pack
// Combinational immediate packer: inserts a sign-extended immediate into the
// immediate field(s) of an instruction template and flags values that the
// selected format cannot represent.
// Ports:
//   template  in   XLEN          instruction word, non-immediate bits kept
//   immtype   in   IMMTYPE_SIZE  immediate format code (I/S/B/U)
//   imm       in   XLEN          sign-extended immediate value
//   instr     out  XLEN          encoded instruction (template on error)
//   err       out  1             immediate unrepresentable or format illegal
module cpu6_immenc_pack
  import cpu6_immenc_pkg::*;
(
  input  logic [CPU6_XLEN-1:0]         template,
  input  logic [CPU6_IMMTYPE_SIZE-1:0] immtype,
  input  logic [CPU6_XLEN-1:0]         imm,
  output logic [CPU6_XLEN-1:0]         instr,
  output logic                         err
);

  // Start from the untouched template and an error flag; each legal format
  // overwrites only its own fields and clears the error when the range check
  // holds. A failed check or unknown format therefore leaves the template
  // exactly as it came in.
  always_comb begin
    instr = template;
    err   = 1'b1;
    case (immtype)
      CPU6_IMMTYPE_I: begin
        if (cpu6_fits_signed(imm, 11)) begin
          instr[CPU6_I_IMM_HI:CPU6_I_IMM_LO] = imm[11:0];
          err = 1'b0;
        end
      end
      CPU6_IMMTYPE_S: begin
        if (cpu6_fits_signed(imm, 11)) begin
          instr[CPU6_S_HI_HI:CPU6_S_HI_LO] = imm[11:5];
          instr[CPU6_S_LO_HI:CPU6_S_LO_LO] = imm[4:0];
          err = 1'b0;
        end
      end
      CPU6_IMMTYPE_B: begin
        // Branch offsets are halfword aligned, so bit 0 must be clear.
        if (cpu6_fits_signed(imm, 12) && !imm[0]) begin
          instr[CPU6_B_BIT12]              = imm[12];
          instr[CPU6_B_HI_HI:CPU6_B_HI_LO] = imm[10:5];
          instr[CPU6_B_LO_HI:CPU6_B_LO_LO] = imm[4:1];
          instr[CPU6_B_BIT11]              = imm[11];
          err = 1'b0;
        end
      end
      CPU6_IMMTYPE_U: begin
        if (imm[11:0] == 12'd0) begin
          instr[CPU6_U_IMM_HI:CPU6_U_IMM_LO] = imm[31:12];
          err = 1'b0;
        end
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu6_immenc.sv
// cpu6_immenc
// Immediate encoder with a two-entry valid/ready buffer (output register plus
// skid register) and delivery counters.
// Ports:
//   clk          in   1             clock, rising edge
//   reset        in   1             asynchronous active-high reset
//   in_valid     in   1             request present
//   in_ready     out  1             request accepted this cycle (skid empty)
//   in_template  in   XLEN          instruction template
//   in_immtype   in   IMMTYPE_SIZE  immediate format
//   in_imm       in   XLEN          sign-extended immediate
//   out_valid    out  1             encoded word present
//   out_ready    in   1             consumer takes the word this cycle
//   out_instr    out  XLEN          encoded instruction
//   out_err      out  1             encoding error flag for out_instr
//   enc_cnt      out  16            wrapping count of delivered words
//   err_cnt      out  8             saturating count of delivered errors
module cpu6_immenc
  import cpu6_immenc_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CPU6_XLEN-1:0]         in_template,
  input  logic [CPU6_IMMTYPE_SIZE-1:0] in_immtype,
  input  logic [CPU6_XLEN-1:0]         in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CPU6_XLEN-1:0]         out_instr,
  output logic                         out_err,
  output logic [15:0]                  enc_cnt,
  output logic [7:0]                   err_cnt
);

  logic [CPU6_XLEN-1:0] enc_instr;
  logic                 enc_err;
  logic                 skid_valid;
  logic [CPU6_XLEN-1:0] skid_instr;
  logic                 skid_err;
  logic                 in_xfer;
  logic                 out_xfer;

  cpu6_immenc_pack u_pack (
    .template (in_template),
    .immtype  (in_immtype),
    .imm      (in_imm),
    .instr    (enc_instr),
    .err      (enc_err)
  );

  // in_ready depends only on skid occupancy, never on in_valid, so the
  // upstream handshake has no combinational loop through this block.
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Buffer update. When the output register is free this cycle (empty or
  // draining) it refills from the skid first, which keeps acceptance order,
  // and otherwise straight from the encoder. When the output is stalled a
  // newly accepted word parks in the skid. A refill from the skid can never
  // coincide with an acceptance because in_ready is low while the skid is
  // full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_err   <= 1'b0;
    end else begin
      if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= skid_instr;
          out_err    <= skid_err;
          skid_valid <= 1'b0;
        end else if (in_xfer) begin
          out_valid  <= 1'b1;
          out_instr  <= enc_instr;
          out_err    <= enc_err;
        end else begin
          out_valid  <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_valid <= 1'b1;
        skid_instr <= enc_instr;
        skid_err   <= enc_err;
      end
    end
  end

  // Delivery counters advance only on a completed out-side handshake, so
  // words thrown away by reset are never counted. enc_cnt wraps naturally;
  // err_cnt sticks at its maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_xfer) begin
      enc_cnt <= enc_cnt + 16'd1;
      if (out_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu6_immenc.sv
// tb_cpu6_immenc
// Self-checking bench for cpu6_immenc: a table of known encodings streamed
// through at full rate, hand-written backpressure and mid-stream reset
// sequences, and a randomized run compared against an arithmetic reference
// model with a queue standing in for the buffer.
module tb_cpu6_immenc;
  import cpu6_immenc_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_template;
  logic [2:0]  in_immtype;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_cnt;
  logic [7:0]  err_cnt;

  int total;
  int bad;

  typedef struct {
    logic [31:0] tmpl;
    logic [2:0]  ty;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } word_t;

  vec_t  vecs[13];
  word_t model_q[$];

  cpu6_immenc dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_template (in_template),
    .in_immtype  (in_immtype),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_err     (out_err),
    .enc_cnt     (enc_cnt),
    .err_cnt     (err_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] t,
                                input logic [2:0] ty, input logic [31:0] imm,
                                input logic ordy);
    in_valid    = v;
    in_template = t;
    in_immtype  = ty;
    in_imm      = imm;
    out_ready   = ordy;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus(1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference encoder built from value ranges and masks/shifts.
  function automatic word_t ref_enc(input logic [31:0] t, input logic [2:0] ty,
                                    input logic [31:0] imm);
    word_t w;
    int    v;
    v = int'($signed(imm));
    w.instr = t;
    w.err   = 1'b1;
    case (ty)
      3'd0: if (v >= -2048 && v <= 2047) begin
        w.instr = (t & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
        w.err = 1'b0;
      end
      3'd1: if (v >= -2048 && v <= 2047) begin
        w.instr = (t & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25)
                | ((imm & 32'h1F) << 7);
        w.err = 1'b0;
      end
      3'd2: if (v >= -4096 && v <= 4095 && (v % 2) == 0) begin
        w.instr = (t & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                | (((imm >> 11) & 32'h1) << 7);
        w.err = 1'b0;
      end
      3'd3: if ((imm % 4096) == 0) begin
        w.instr = (t & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
        w.err = 1'b0;
      end
      default: w.err = 1'b1;
    endcase
    return w;
  endfunction

  initial begin
    int          exp_enc;
    int          exp_err;
    logic [31:0] t;
    logic [2:0]  ty;
    logic [31:0] imm;
    logic        iv;
    logic        ordy;
    word_t       w;
    word_t       front;
    bit          do_in;
    bit          do_out;

    total = 0;
    bad   = 0;

    vecs[0]  = '{32'h0000_0013, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0};
    vecs[1]  = '{32'h0000_2023, 3'd1, 32'h0000_0008, 32'h0000_2423, 1'b0};
    vecs[2]  = '{32'h0000_0063, 3'd2, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vecs[3]  = '{32'h0000_00B7, 3'd3, 32'h1234_5000, 32'h1234_50B7, 1'b0};
    vecs[4]  = '{32'h0000_00B7, 3'd3, 32'h1234_5001, 32'h0000_00B7, 1'b1};
    vecs[5]  = '{32'h0000_0013, 3'd0, 32'h0000_0800, 32'h0000_0013, 1'b1};
    vecs[6]  = '{32'h0000_0063, 3'd2, 32'h0000_0003, 32'h0000_0063, 1'b1};
    vecs[7]  = '{32'hDEAD_BEEF, 3'd5, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{32'h0000_0013, 3'd0, 32'h0000_07FF, 32'h7FF0_0013, 1'b0};
    vecs[9]  = '{32'h0000_0013, 3'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
    vecs[10] = '{32'h0000_2023, 3'd1, 32'hFFFF_F800, 32'h8000_2023, 1'b0};
    vecs[11] = '{32'h0000_0063, 3'd2, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    vecs[12] = '{32'h0000_0063, 3'd2, 32'h0000_1000, 32'h0000_0063, 1'b1};

    // Reset state.
    do_reset();
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_output("rst_out_instr", out_instr,          32'd0);
    check_output("rst_out_err",   {31'd0, out_err},   32'd0);
    check_output("rst_enc_cnt",   {16'd0, enc_cnt},   32'd0);
    check_output("rst_err_cnt",   {24'd0, err_cnt},   32'd0);

    // Table vectors streamed at full rate from the first cycle after reset:
    // each word must appear one cycle after acceptance while the previous
    // one drains in the same cycle.
    exp_err = 0;
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b1, vecs[i].tmpl, vecs[i].ty, vecs[i].imm, 1'b1);
      tick();
      check_output($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_output($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
      check_output($sformatf("vec%0d_err", i), {31'd0, out_err},
                   {31'd0, vecs[i].exp_err});
      w = ref_enc(vecs[i].tmpl, vecs[i].ty, vecs[i].imm);
      check_output($sformatf("vec%0d_model", i), w.instr, vecs[i].exp_instr);
      if (vecs[i].exp_err) exp_err++;
    end
    apply_stimulus(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
    tick();
    check_output("tbl_drained", {31'd0, out_valid}, 32'd0);
    check_output("tbl_enc_cnt", {16'd0, enc_cnt}, 32'd13);
    check_output("tbl_err_cnt", {24'd0, err_cnt}, 32'(exp_err));

    // Backpressure: three back-to-back requests with the consumer stalled.
    do_reset();
    apply_stimulus(1'b1, 32'h0000_0013, 3'd0, 32'h0000_0001, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h0000_0013, 3'd0, 32'h0000_0002, 1'b0);
    tick();
    check_output("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    check_output("bp_first_held", out_instr, 32'h0010_0013);
    apply_stimulus(1'b1, 32'h0000_0013, 3'd0, 32'h0000_0003, 1'b0);
    tick();
    check_output("bp_still_full", {31'd0, in_ready}, 32'd0);
    check_output("bp_enc_hold", {16'd0, enc_cnt}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_output("bp_second_out", out_instr, 32'h0020_0013);
    check_output("bp_in_ready_free", {31'd0, in_ready}, 32'd1);
    tick();
    check_output("bp_third_out", out_instr, 32'h0030_0013);
    check_output("bp_enc_cnt2", {16'd0, enc_cnt}, 32'd2);
    in_valid = 1'b0;
    tick();
    check_output("bp_enc_cnt3", {16'd0, enc_cnt}, 32'd3);
    check_output("bp_empty", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream with both entries holding words.
    apply_stimulus(1'b1, 32'h0000_00B7, 3'd3, 32'h1234_5001, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h0000_00B7, 3'd3, 32'hABCD_E000, 1'b0);
    tick();
    check_output("mr_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_output("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("mr_in_ready",  {31'd0, in_ready},  32'd1);
    check_output("mr_enc_cnt",   {16'd0, enc_cnt},   32'd0);
    check_output("mr_err_cnt",   {24'd0, err_cnt},   32'd0);
    check_output("mr_out_instr", out_instr,          32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output($sformatf("mr_no_stale%0d", i), {31'd0, out_valid}, 32'd0);
    end
    check_output("mr_enc_after", {16'd0, enc_cnt}, 32'd0);

    // Randomized traffic against the queue model.
    do_reset();
    exp_enc = 0;
    exp_err = 0;
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      t    = $urandom;
      ty   = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3))
                                         : 3'($urandom_range(4, 7));
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 4)) - 32'd2;
      endcase
      apply_stimulus(iv, t, ty, imm, ordy);

      check_output("rnd_in_ready", {31'd0, in_ready},
                   (model_q.size() < 2) ? 32'd1 : 32'd0);
      check_output("rnd_out_valid", {31'd0, out_valid},
                   (model_q.size() > 0) ? 32'd1 : 32'd0);
      check_output("rnd_enc_cnt", {16'd0, enc_cnt}, 32'(exp_enc));
      check_output("rnd_err_cnt", {24'd0, err_cnt}, 32'(exp_err));

      do_out = ordy && (model_q.size() > 0);
      do_in  = iv && (model_q.size() < 2);
      if (do_out) begin
        front = model_q.pop_front();
        check_output("rnd_instr", out_instr, front.instr);
        check_output("rnd_err", {31'd0, out_err}, {31'd0, front.err});
        exp_enc = (exp_enc + 1) % 65536;
        if (front.err && exp_err < 255) exp_err++;
      end
      if (do_in) model_q.push_back(ref_enc(t, ty, imm));
      tick();
    end

    // Drain whatever is left, bounded.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && model_q.size() > 0; c++) begin
      check_output("drain_valid", {31'd0, out_valid}, 32'd1);
      front = model_q.pop_front();
      check_output("drain_instr", out_instr, front.instr);
      exp_enc = (exp_enc + 1) % 65536;
      if (front.err && exp_err < 255) exp_err++;
      tick();
    end
    check_output("drain_left", 32'(model_q.size()), 32'd0);
    check_output("drain_empty", {31'd0, out_valid}, 32'd0);
    check_output("final_enc_cnt", {16'd0, enc_cnt}, 32'(exp_enc));
    check_output("final_err_cnt", {24'd0, err_cnt}, 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu6_immenc.md
CPU6_IMMENC -- requirements
Module: cpu6_immenc

Interface
REQ-001 Parameter: none; widths come from the shared defines (`CPU6_XLEN` = 32, `CPU6_IMMTYPE_SIZE`).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  the block accepts the request this cycle.
REQ-006 in_template  input  XLEN  instruction word; the bits outside the immediate field are passed through.
REQ-007 in_immtype  input  IMMTYPE_SIZE  immediate format: I, S, B or U.
REQ-008 in_imm  input  XLEN  sign-extended immediate value to insert.
REQ-009 out_valid  output  1  encoded word present.
REQ-010 out_ready  input  1  the consumer takes the word this cycle.
REQ-011 out_instr  output  XLEN  encoded instruction.
REQ-012 out_err  output  1  immediate is not representable, or immtype is illegal.
REQ-013 enc_cnt  output  16  wrapping count of words delivered.
REQ-014 err_cnt  output  8  saturating count of delivered words with out_err=1.

Function
REQ-015 A transfer occurs on the in side when in_valid&in_ready, and on the out side when out_valid&out_ready.
REQ-016 The block is a two-entry buffer: an output register plus a skid register.
REQ-017 in_ready = !skid_full; in_ready does not depend combinationally on in_valid.
REQ-018 Latency: a word accepted at cycle N is presented with out_valid at N+1 when the output register is empty or drains at N.
REQ-019 Words leave the block in acceptance order; none is dropped or duplicated under any backpressure pattern.
REQ-020 A simultaneous in-transfer and out-transfer with the skid register empty loads the output register directly, and occupancy is unchanged.
REQ-021 When the output register is stalled, an accepted word goes to the skid register; the skid register moves to the output register on the next out-transfer.
REQ-022 I format: instr[31:20] = imm[11:0].
REQ-023 S format: instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
REQ-024 B format: instr[31] = imm[12]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1]; instr[7] = imm[11].
REQ-025 U format: instr[31:12] = imm[31:12].
REQ-026 All bit positions not named for the selected format equal in_template.
REQ-027 Range check for I and S: imm[31:11] all equal.
REQ-028 Range check for B: imm[31:12] all equal, and imm[0] = 0.
REQ-029 Range check for U: imm[11:0] = 0.
REQ-030 On a range-check failure or an illegal immtype: out_err = 1 and out_instr = in_template unmodified.
REQ-031 Encoding and range check are computed before the buffer, and the result is registered with the word.
REQ-032 enc_cnt increments by 1 per out-transfer and wraps from 0xFFFF to 0.
REQ-033 err_cnt increments per out-transfer carrying out_err=1 and holds at 0xFF.

Reset
REQ-034 Reset clears both buffer entries asynchronously: out_valid = 0, in_ready = 1.
REQ-035 Under reset: out_instr = 0, out_err = 0, enc_cnt = 0, err_cnt = 0.
REQ-036 Reset asserted mid-operation discards buffered words without delivering them.
REQ-037 Counters do not count words discarded by reset.
REQ-038 The first transfer after reset is possible in the cycle after reset deasserts.

Structure
REQ-039 The `CPU6_IMMTYPE_*` codes and the immediate field bit positions live in the shared defines file, which the matching immediate decoder also uses; the block does not duplicate these constants locally.
REQ-040 The combinational encoder plus range check is one sub-module, cpu6_immenc_pack (template, immtype, imm -> instr, err).
REQ-041 The buffer and the counters are in cpu6_immenc.

Verification
REQ-042 I: template 0x00000013, imm 0xFFFFFFFF -> out_instr 0xFFF00013, err 0, one cycle after acceptance.
REQ-043 S: template 0x00002023, imm 0x00000008 -> 0x00002423. B: template 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3.
REQ-044 U: template 0x000000B7, imm 0x12345000 -> 0x123450B7. U with imm 0x12345001 -> 0x000000B7, err 1, err_cnt 1.
REQ-045 Error cases: I imm 0x00000800 -> err 1. B imm 0x00000003 -> err 1. Illegal immtype -> err 1 with the template unchanged.
REQ-046 Backpressure: out_ready=0 with 3 back-to-back valid inputs -> 2 accepted, in_ready=0 in the third cycle; on release, words emerge in order and enc_cnt = 2 (then 3 after the third is accepted and drained).
REQ-047 Reset mid-stream with both entries full -> out_valid falls immediately, in_ready = 1, counters = 0, and no stale word appears afterward.
